// File: rtl/alu_resp_packetizer_if.sv
// Handshake bundle between the ALU path, the response packetizer and the UART TX.
// Upstream: opcode_i/result_i/valid_i/ready_o. Downstream: data_o/valid_o/ready_i. done_o: packet-complete pulse.
interface alu_resp_packetizer_if #(
    parameter int width_p = 32
);
    logic [7:0]         opcode_i;
    logic [width_p-1:0] result_i;
    logic               valid_i;
    logic               ready_o;
    logic [7:0]         data_o;
    logic               valid_o;
    logic               ready_i;
    logic               done_o;

    modport slave (
        input  opcode_i,
        input  result_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output valid_o,
        output done_o
    );

    modport master (
        output opcode_i,
        output result_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  valid_o,
        input  done_o
    );
endinterface

// File: rtl/alu_resp_packetizer.sv
// Serialises one opcode + ALU result into a byte packet: op, 0x00, len lo, len hi, result LSB-first.
// Ports: clk, rst (sync, active-low), bus (slave side of alu_resp_packetizer_if).
module alu_resp_packetizer #(
    parameter int width_p = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_resp_packetizer_if.slave  bus
);
    localparam int bytes_p = width_p / 8;
    localparam int idx_w   = (bytes_p > 1) ? $clog2(bytes_p) : 1;

    // Length counts the whole packet, header included.
    localparam logic [15:0]      len_c  = 16'(4 + bytes_p);
    localparam logic [idx_w-1:0] last_c = idx_w'(bytes_p - 1);

    typedef enum logic [2:0] {
        IDLE,
        OP,
        RSV,
        LEN_LO,
        LEN_HI,
        PAYLOAD
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [width_p-1:0] res_q, res_d;
    logic [idx_w-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               xfer;

    // Everything the downstream sees is decoded from registers only,
    // so ready_i never reaches data_o combinationally.
    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q != IDLE);
    assign bus.done_o  = done_q;
    assign xfer        = bus.valid_o && bus.ready_i;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_d      = res_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        bus.data_o = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    state_d = OP;
                    op_d    = bus.opcode_i;
                    res_d   = bus.result_i;
                    idx_d   = '0;
                end
            end
            OP: begin
                bus.data_o = op_q;
                if (xfer) state_d = RSV;
            end
            RSV: begin
                bus.data_o = 8'h00;
                if (xfer) state_d = LEN_LO;
            end
            LEN_LO: begin
                bus.data_o = len_c[7:0];
                if (xfer) state_d = LEN_HI;
            end
            LEN_HI: begin
                bus.data_o = len_c[15:8];
                if (xfer) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                bus.data_o = res_q[8*idx_q +: 8];
                if (xfer) begin
                    if (idx_q == last_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/alu_resp_packetizer.md
Name: alu_resp_packetizer

Overview:
- Downstream neighbour of the command FSM/ALU path. Accepts one completed ALU result word plus its opcode over a valid/ready handshake.
- Serialises them into a response packet of bytes for the UART transmitter, which is the downstream byte consumer.
- Packet format mirrors the command framing: opcode, reserved 0x00, length LSB, length MSB, then result bytes LSB-first.
- Length field equals the total packet byte count, header included.

Parameters:
width_p, 32, result word width in bits; must be a multiple of 8, range 8..64
bytes_p, width_p/8, number of payload bytes (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge)
opcode_i  input  8  opcode to echo in byte 0 of the response; not decoded
result_i  input  width_p  ALU result word
valid_i  input  1  opcode_i/result_i valid (from upstream)
ready_o  output  1  packetizer can accept a result (to upstream)
data_o  output  8  response byte (to UART TX)
valid_o  output  1  data_o valid (to UART TX)
ready_i  input  1  UART TX accepts byte (from downstream)
done_o  output  1  one-cycle pulse after the last packet byte handshakes

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, ready_o=1, valid_o=0, data_o=0x00, done_o=0, holding registers cleared.
- Reset mid-packet aborts the packet; no further bytes are emitted.
- Upstream handshake:
  - Capture opcode_i and result_i into registers on an edge with valid_i&&ready_o.
  - ready_o=1 only in IDLE; it is combinational from state only, never from valid_i.
- Downstream handshake:
  - A byte transfers on an edge with valid_o&&ready_i.
  - While valid_o=1 and ready_i=0, data_o is held stable and valid_o stays high.
  - valid_o never drops without a handshake, except on reset.
- States and transitions:
  - IDLE -> OP on accept.
  - OP -> RSV -> LEN_LO -> LEN_HI -> PAYLOAD, each on a byte handshake.
  - PAYLOAD -> IDLE on the handshake of payload byte bytes_p-1.
- Byte values by state:
  - OP: data_o = captured opcode.
  - RSV: data_o = 0x00.
  - LEN_LO: data_o = len[7:0]. LEN_HI: data_o = len[15:8], where len = 4+bytes_p as 16-bit (0x0008 for width_p=32).
  - PAYLOAD: data_o = result[8*k+7:8*k], with k = byte index 0..bytes_p-1.
  - The byte index counter resets to 0 on accept and increments on each PAYLOAD handshake; no wrap past bytes_p-1.
- Latency:
  - Accept at edge N gives valid_o=1 with the opcode byte during cycle N+1.
  - With ready_i held high, the packet occupies exactly 4+bytes_p consecutive cycles.
  - The last handshake at edge M gives done_o=1 and ready_o=1 during cycle M+1. No same-cycle accept of the next result (one bubble minimum).
- valid_i while busy is ignored; upstream must hold it until ready_o.
- valid_o is 0 in IDLE, and data_o=0x00 in IDLE.
- Output registers are stable; no combinational path from ready_i to data_o.

Test Plan:
1. Reset, then opcode_i=0xA5, result_i=0x12345678, valid_i one cycle, ready_i=1 -> bytes A5,00,08,00,78,56,34,12 on 8 consecutive cycles starting cycle after accept; done_o pulses once; ready_o=1 the following cycle.
2. Same stimulus with ready_i toggling 1,0,0,1,... -> identical byte sequence; data_o/valid_o stable on every ready_i=0 cycle; no byte duplicated or lost.
3. valid_i held high with new result 0xDEADBEEF during packet 1 -> not accepted until ready_o=1; second packet A5,00,08,00,EF,BE,AD,DE follows after exactly one idle cycle.
4. Assert rst=0 while in PAYLOAD at byte index 2 -> next cycle valid_o=0, ready_o=1, done_o=0; a subsequent request emits a full fresh packet from the opcode byte.
5. width_p=64, result 0x0102030405060708 -> length bytes 0C,00 and payload 08,07,06,05,04,03,02,01; 12 bytes total.
6. result_i=0x00000000, opcode_i=0x00 -> 00,00,08,00,00,00,00,00 (zero payload still fully emitted).
